sram_quad_ref_reader: RTL and testbench
=======================================

// Module: sram_quad_ref_reader
// PURPOSE
//   Downstream consumer of the SRAM reference table written by the flash-to-SRAM loader
//   (65536 x 16-bit two's-complement samples, one full sine period).
//   A phase accumulator steps through the table per sample tick; each tick issues two SRAM reads
//   (I at phase, Q at phase+90 deg) and emits a sin/cos pair for the lock-in mixers.
//   Holds off all SRAM reads while the loader is busy.
// PARAMETERS
//   RD_LAT     1             SRAM read latency in clk cycles, ren -> rdata valid (1..4)
//   QUAD_OFS   16'h4000      address offset of Q read relative to I read (90 deg)
// PORTS
//   clk        in   1   system clock, all logic on rising edge
//   rst        in   1   asynchronous, active-low reset
//   enable     in   1   run enable; low aborts any in-flight read and blocks ticks
//   load_busy  in   1   busy from loader; high = SRAM owned by loader, no reads allowed
//   tick       in   1   one-cycle sample strobe requesting a new sin/cos pair
//   ftw        in   32  frequency tuning word, added to phase per accepted tick
//   phase_ofs  in   16  phase offset added to table address (not accumulated)
//   phase_clr  in   1   synchronous clear of phase accumulator and overrun flag
//   ren        out  1   SRAM read enable, one cycle per read
//   raddr      out  16  SRAM read address
//   rdata      in   16  SRAM read data, valid RD_LAT cycles after ren
//   sin_out    out  16  signed I sample (table value at phase)
//   cos_out    out  16  signed Q sample (table value at phase+QUAD_OFS)
//   valid      out  1   one-cycle strobe: sin_out/cos_out updated
//   overrun    out  1   sticky: tick arrived while a read pair was still in progress
// BEHAVIOUR
// - Reset (rst low, async): phase=0, state IDLE, ren=0, raddr=0, sin_out=0, cos_out=0, valid=0, overrun=0.
// - States: IDLE -> RD_I -> RD_Q -> WAIT -> IDLE.
// - Accept: tick && enable && !load_busy && !phase_clr && state==IDLE.
//   On accept: latch a = phase[31:16]+phase_ofs (mod 2^16), then phase <= phase+ftw (mod 2^32),
//   state -> RD_I.
// - RD_I (1 cycle): ren=1, raddr=a.  RD_Q (1 cycle): ren=1, raddr=a+QUAD_OFS (mod 2^16).
// - WAIT: counts until the Q data arrives (RD_LAT-1 cycles after RD_Q; 0 cycles when RD_LAT=1).
//   I data is captured RD_LAT cycles after RD_I, Q data RD_LAT cycles after RD_Q.
// - Output: sin_out/cos_out load both captured values together; valid=1 for exactly one cycle.
//   Tick in cycle T (accepted) -> valid high in cycle T+3+RD_LAT.  Outputs hold between strobes.
// - ren is low in every cycle not in RD_I/RD_Q; raddr holds its last value.
// - Tick when state!=IDLE: dropped, overrun<=1 (sticky).  Phase does not advance.
// - Tick while load_busy or !enable: dropped silently, overrun unchanged, phase unchanged.
// - load_busy or !enable going high in any non-IDLE state: abort; state -> IDLE next edge,
//   ren=0 from that cycle, no valid for the aborted pair, outputs keep previous values,
//   late rdata from already-issued reads is ignored.
// - phase_clr: phase<=0, overrun<=0; has priority over a same-cycle tick (tick dropped,
//   no overrun).  An in-flight pair completes normally (address already latched).
// - ftw/phase_ofs are sampled only at accept; changes mid-pair take effect on next tick.
// - ftw=0: every tick reads the same address pair (DC reference).
// TESTING
// 1. Reset, RD_LAT=1, SRAM model table[i]=i, ftw=32'h0001_0000, phase_ofs=0, tick every 16 cycles
//    -> ren pairs at addr 0/4000h, 1/4001h, 2/4002h...; valid at T+4; sin_out=0,1,2..., cos_out=4000h,4001h...
// 2. ftw=32'h8000_0000, phase_ofs=16'hC000 -> addresses C000h/0000h then 4000h/8000h (wrap mod 2^16).
// 3. Two ticks 2 cycles apart -> second dropped, overrun=1, only one valid;
//    phase_clr pulse -> overrun=0, next accepted tick reads addr phase_ofs.
// 4. load_busy raised 1 cycle after accepted tick -> no valid, ren=0 from next cycle, outputs unchanged;
//    ticks during busy -> no ren, overrun stays 0; after busy falls next tick proceeds.
// 5. RD_LAT=3 -> valid exactly 6 cycles after tick, sin/cos match table values at issued addresses.
// 6. rst asserted low mid-pair (async, between edges) -> ren, valid, outputs, phase, overrun all 0 immediately.

Source files
------------

// File: rtl/sram_quad_ref_reader_if.sv
// SRAM read port shared by the quadrature reference reader and its SRAM.
interface sram_quad_ref_reader_if;
    logic        ren;
    logic [15:0] raddr;
    logic [15:0] rdata;

    modport master (output ren, output raddr, input rdata);
    modport slave  (input ren, input raddr, output rdata);
endinterface

// File: rtl/sram_quad_ref_reader.sv
// Phase-accumulator reader of the SRAM sine table: per accepted tick it reads the
// I sample at phase and the Q sample a quarter period later, then emits both together.
module sram_quad_ref_reader #(
    parameter int unsigned RD_LAT   = 1,
    parameter logic [15:0] QUAD_OFS = 16'h4000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          load_busy,
    input  logic                          tick,
    input  logic [31:0]                   ftw,
    input  logic [15:0]                   phase_ofs,
    input  logic                          phase_clr,
    sram_quad_ref_reader_if.master        sram,
    output logic [15:0]                   sin_out,
    output logic [15:0]                   cos_out,
    output logic                          valid,
    output logic                          overrun
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned PW = 32;
    localparam int unsigned CW = 2;
    localparam logic [CW-1:0] WAIT_LAST = CW'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD_I = 2'd1,
        S_RD_Q = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t        state, state_d;
    logic [PW-1:0] phase, phase_d;
    logic [AW-1:0] addr_a, addr_a_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic          ren_q, ren_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          overrun_d;
    logic          abort_c;
    logic          accept_c;

    // Per-stage tags marking which rdata cycles carry live I / Q samples
    logic [RD_LAT-1:0] pipe_i, pipe_q;
    logic [RD_LAT:0]   pipe_i_nx, pipe_q_nx;
    logic              i_hit_c, q_hit_c;
    logic [DW-1:0]     i_cap;

    assign abort_c  = (state != S_IDLE) && (load_busy || !enable);
    assign accept_c = tick && enable && !load_busy && !phase_clr && (state == S_IDLE);

    // Next-state, accumulator and read-port logic
    always_comb begin
        state_d   = state;
        phase_d   = phase;
        addr_a_d  = addr_a;
        raddr_d   = raddr_q;
        ren_d     = 1'b0;
        cnt_d     = cnt;
        overrun_d = overrun;

        if (phase_clr) begin
            phase_d   = '0;
            overrun_d = 1'b0;
        end else if (tick && enable && !load_busy && (state != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        if (abort_c) begin
            state_d = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept_c) begin
                        addr_a_d = AW'(phase[PW-1:PW-AW] + phase_ofs);
                        phase_d  = PW'(phase + ftw);
                        raddr_d  = addr_a_d;
                        ren_d    = 1'b1;
                        state_d  = S_RD_I;
                    end
                end
                S_RD_I: begin
                    raddr_d = AW'(addr_a + QUAD_OFS);
                    ren_d   = 1'b1;
                    state_d = S_RD_Q;
                end
                S_RD_Q: begin
                    if (RD_LAT > 1) begin
                        cnt_d   = WAIT_LAST;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = CW'(cnt - CW'(1));
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            phase   <= '0;
            addr_a  <= '0;
            raddr_q <= '0;
            ren_q   <= 1'b0;
            cnt     <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_d;
            phase   <= phase_d;
            addr_a  <= addr_a_d;
            raddr_q <= raddr_d;
            ren_q   <= ren_d;
            cnt     <= cnt_d;
            overrun <= overrun_d;
        end
    end

    assign sram.ren   = ren_q;
    assign sram.raddr = raddr_q;

    assign pipe_i_nx = {pipe_i, (state == S_RD_I)};
    assign pipe_q_nx = {pipe_q, (state == S_RD_Q)};
    assign i_hit_c   = pipe_i[RD_LAT-1] && !abort_c;
    assign q_hit_c   = pipe_q[RD_LAT-1] && !abort_c;

    // Read-latency tracking; an abort discards every read already in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_i <= '0;
            pipe_q <= '0;
        end else if (abort_c) begin
            pipe_i <= '0;
            pipe_q <= '0;
        end else begin
            pipe_i <= pipe_i_nx[RD_LAT-1:0];
            pipe_q <= pipe_q_nx[RD_LAT-1:0];
        end
    end

    // Hold I until Q lands so both outputs change in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_cap   <= '0;
            sin_out <= '0;
            cos_out <= '0;
            valid   <= 1'b0;
        end else begin
            valid <= q_hit_c;
            if (i_hit_c) begin
                i_cap <= sram.rdata;
            end
            if (q_hit_c) begin
                sin_out <= i_cap;
                cos_out <= sram.rdata;
            end
        end
    end

endmodule

// File: tb/tb_sram_quad_ref_reader.sv
// Directed bench: instance A uses a 1-cycle SRAM, instance B a 3-cycle SRAM; table[i] = i.
module tb_sram_quad_ref_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        load_busy = 1'b0;
    logic        tick_a = 1'b0;
    logic        tick_b = 1'b0;
    logic [31:0] ftw = '0;
    logic [15:0] phase_ofs = '0;
    logic        phase_clr = 1'b0;
    logic [15:0] sin_a, cos_a, sin_b, cos_b;
    logic        valid_a, ovr_a, valid_b, ovr_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_quad_ref_reader_if if_a ();
    sram_quad_ref_reader_if if_b ();

    sram_quad_ref_reader #(.RD_LAT(1), .QUAD_OFS(16'h4000)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .load_busy(load_busy), .tick(tick_a),
        .ftw(ftw), .phase_ofs(phase_ofs), .phase_clr(phase_clr), .sram(if_a.master),
        .sin_out(sin_a), .cos_out(cos_a), .valid(valid_a), .overrun(ovr_a)
    );

    sram_quad_ref_reader #(.RD_LAT(3), .QUAD_OFS(16'h4000)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .load_busy(load_busy), .tick(tick_b),
        .ftw(ftw), .phase_ofs(phase_ofs), .phase_clr(phase_clr), .sram(if_b.master),
        .sin_out(sin_b), .cos_out(cos_b), .valid(valid_b), .overrun(ovr_b)
    );

    // SRAM models: data equals address on the valid cycle, garbage otherwise
    logic        a_en = 1'b0;
    logic [15:0] a_ad = '0;
    always @(posedge clk) begin
        a_en <= if_a.ren;
        a_ad <= if_a.raddr;
    end
    assign if_a.rdata = a_en ? a_ad : 16'hBAD0;

    logic [2:0]  b_en = '0;
    logic [15:0] b_ad0 = '0, b_ad1 = '0, b_ad2 = '0;
    always @(posedge clk) begin
        b_en  <= {b_en[1:0], if_b.ren};
        b_ad0 <= if_b.raddr;
        b_ad1 <= b_ad0;
        b_ad2 <= b_ad1;
    end
    assign if_b.rdata = b_en[2] ? b_ad2 : 16'hBAD0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accepted tick on A (called right after an edge); checks ren pair and T+4 strobe
    task automatic pair_a(input logic [15:0] a);
        logic [15:0] q;
        q = a + 16'h4000;
        tick_a = 1'b1;
        cyc();
        tick_a = 1'b0;
        chk("a_ren_i", 32'(if_a.ren), 32'd1);
        chk("a_raddr_i", 32'(if_a.raddr), 32'(a));
        cyc();
        chk("a_ren_q", 32'(if_a.ren), 32'd1);
        chk("a_raddr_q", 32'(if_a.raddr), 32'(q));
        cyc();
        chk("a_ren_off", 32'(if_a.ren), 32'd0);
        chk("a_valid_early", 32'(valid_a), 32'd0);
        cyc();
        chk("a_valid", 32'(valid_a), 32'd1);
        chk("a_sin", 32'(sin_a), 32'(a));
        chk("a_cos", 32'(cos_a), 32'(q));
        cyc();
        chk("a_valid_pulse", 32'(valid_a), 32'd0);
        chk("a_sin_hold", 32'(sin_a), 32'(a));
        repeat (10) cyc();
    endtask

    initial begin
        int nval;
        int nact;

        // Reset state
        repeat (3) cyc();
        chk("rst_ren", 32'(if_a.ren), 32'd0);
        chk("rst_raddr", 32'(if_a.raddr), 32'd0);
        chk("rst_sin", 32'(sin_a), 32'd0);
        chk("rst_cos", 32'(cos_a), 32'd0);
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_ovr", 32'(ovr_a), 32'd0);
        rst = 1'b1;
        enable = 1'b1;
        ftw = 32'h0001_0000;
        cyc();

        // Sequential table walk
        pair_a(16'h0000);
        pair_a(16'h0001);
        pair_a(16'h0002);

        // Half-period steps with offset, address wrap
        phase_clr = 1'b1;
        cyc();
        phase_clr = 1'b0;
        ftw = 32'h8000_0000;
        phase_ofs = 16'hC000;
        pair_a(16'hC000);
        pair_a(16'h4000);

        // Overrun: second tick during the pair is dropped
        ftw = 32'h0001_0000;
        phase_ofs = 16'h1234;
        tick_a = 1'b1;
        cyc();
        tick_a = 1'b0;
        cyc();
        tick_a = 1'b1;
        cyc();
        tick_a = 1'b0;
        chk("ovr_set", 32'(ovr_a), 32'd1);
        nval = 0;
        for (int i = 0; i < 8; i++) begin
            nval += int'(valid_a);
            cyc();
        end
        chk("ovr_one_valid", 32'(nval), 32'd1);
        chk("ovr_sin", 32'(sin_a), 32'h1234);
        chk("ovr_sticky", 32'(ovr_a), 32'd1);
        phase_clr = 1'b1;
        cyc();
        phase_clr = 1'b0;
        chk("clr_ovr", 32'(ovr_a), 32'd0);
        tick_a = 1'b1;
        phase_clr = 1'b1;
        cyc();
        tick_a = 1'b0;
        phase_clr = 1'b0;
        chk("clr_tick_ren", 32'(if_a.ren), 32'd0);
        chk("clr_tick_ovr", 32'(ovr_a), 32'd0);
        cyc();
        pair_a(16'h1234);

        // Abort by load_busy one cycle after accept; ticks during busy dropped
        tick_a = 1'b1;
        cyc();
        tick_a = 1'b0;
        load_busy = 1'b1;
        chk("busy_ren_i", 32'(if_a.ren), 32'd1);
        chk("busy_raddr_i", 32'(if_a.raddr), 32'h1235);
        cyc();
        chk("busy_ren_off", 32'(if_a.ren), 32'd0);
        nact = 0;
        for (int i = 0; i < 8; i++) begin
            tick_a = (i % 2 == 0);
            cyc();
            nact += int'(if_a.ren) + int'(valid_a);
        end
        tick_a = 1'b0;
        chk("busy_no_activity", 32'(nact), 32'd0);
        chk("busy_ovr", 32'(ovr_a), 32'd0);
        chk("busy_sin_hold", 32'(sin_a), 32'h1234);
        chk("busy_cos_hold", 32'(cos_a), 32'h5234);
        load_busy = 1'b0;
        cyc();
        pair_a(16'h1236);

        // Tick while disabled is dropped
        enable = 1'b0;
        tick_a = 1'b1;
        cyc();
        tick_a = 1'b0;
        enable = 1'b1;
        chk("dis_ren", 32'(if_a.ren), 32'd0);
        chk("dis_ovr", 32'(ovr_a), 32'd0);
        cyc();

        // Three-cycle read latency on instance B
        phase_ofs = 16'h00F0;
        tick_b = 1'b1;
        cyc();
        tick_b = 1'b0;
        chk("b_ren_i", 32'(if_b.ren), 32'd1);
        chk("b_raddr_i", 32'(if_b.raddr), 32'h00F0);
        cyc();
        chk("b_ren_q", 32'(if_b.ren), 32'd1);
        chk("b_raddr_q", 32'(if_b.raddr), 32'h40F0);
        cyc();
        chk("b_ren_off", 32'(if_b.ren), 32'd0);
        cyc();
        cyc();
        chk("b_valid_early", 32'(valid_b), 32'd0);
        cyc();
        chk("b_valid", 32'(valid_b), 32'd1);
        chk("b_sin", 32'(sin_b), 32'h00F0);
        chk("b_cos", 32'(cos_b), 32'h40F0);
        cyc();
        chk("b_valid_pulse", 32'(valid_b), 32'd0);
        repeat (4) cyc();

        // Asynchronous reset mid-pair
        phase_ofs = 16'h0000;
        tick_a = 1'b1;
        cyc();
        cyc();
        tick_a = 1'b0;
        chk("pre_rst_ovr", 32'(ovr_a), 32'd1);
        chk("pre_rst_ren", 32'(if_a.ren), 32'd1);
        #3 rst = 1'b0;
        #1;
        chk("arst_ren", 32'(if_a.ren), 32'd0);
        chk("arst_raddr", 32'(if_a.raddr), 32'd0);
        chk("arst_valid", 32'(valid_a), 32'd0);
        chk("arst_sin", 32'(sin_a), 32'd0);
        chk("arst_cos", 32'(cos_a), 32'd0);
        chk("arst_ovr", 32'(ovr_a), 32'd0);
        chk("arst_b_sin", 32'(sin_b), 32'd0);
        cyc();
        rst = 1'b1;
        cyc();
        pair_a(16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
